// File: rtl/concrete_round_ctrl.sv
// concrete_round_ctrl
// Sequences one permutation state through NUM_ROUNDS passes of the shared
// concrete linear-layer datapath. Each round takes two cycles: ISSUE presents
// the state to the datapath, and CAPTURE reads back the result. The round
// constants are selected by rc_addr during CAPTURE. The controller only moves
// data. All field arithmetic happens inside concrete.
module concrete_round_ctrl #(
  parameter int N_BITS     = 254,
  parameter int STATE_SIZE = 3,
  parameter int NUM_ROUNDS = 7,
  parameter int RC_ADDR_W  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0] in_state,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [STATE_SIZE-1:0][N_BITS-1:0] out_state,
  output logic [STATE_SIZE-1:0][N_BITS-1:0] dp_in_state,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0] dp_out_state,
  output logic [RC_ADDR_W-1:0]              rc_addr,
  output logic                              busy,
  output logic [RC_ADDR_W-1:0]              round_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } fsm_t;

  localparam logic [RC_ADDR_W-1:0] LAST_ROUND = RC_ADDR_W'(NUM_ROUNDS - 1);

  fsm_t                              fsm, fsm_nxt;
  logic [RC_ADDR_W-1:0]              round, round_nxt;
  logic [STATE_SIZE-1:0][N_BITS-1:0] state_reg, state_nxt;

  // State register: FSM, round counter and the held permutation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= '0;
      // NOTE: the state holding register is cleared on reset even though it
      // is datapath storage, because out_state must read zero out of reset.
      state_reg <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      fsm       <= fsm_nxt;
      round     <= round_nxt;
      state_reg <= state_nxt;
    end
  end

  // Next-state logic: accept, alternate ISSUE/CAPTURE per round, then hold in DONE.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    fsm_nxt   = fsm;
    round_nxt = round;
    state_nxt = state_reg;
    unique case (fsm)
      IDLE: begin
        if (in_valid) begin
          state_nxt = in_state;
          round_nxt = '0;
          fsm_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        fsm_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = dp_out_state;
        if (round == LAST_ROUND) begin
          round_nxt = '0;
          fsm_nxt   = DONE;
        end else begin
          round_nxt = round + 1'b1;
          fsm_nxt   = ISSUE;
        end
      end
      DONE: begin
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign in_ready    = (fsm == IDLE);
  assign out_valid   = (fsm == DONE);
  assign busy        = (fsm == ISSUE) || (fsm == CAPTURE);
  assign dp_in_state = state_reg;
  assign out_state   = state_reg;
  assign rc_addr     = round;
  assign round_idx   = round;

endmodule

// File: tb/tb_concrete_round_ctrl.sv
// tb_concrete_round_ctrl
// Three controller instances with NUM_ROUNDS = 7, 1 and 2. Each one drives a
// behavioural concrete datapath and a constant ROM table. Expected results come
// from hand-derived vectors and from a round-by-round reference permutation.
module tb_concrete_round_ctrl;

  localparam int NB = 254;
  localparam int SS = 3;
  localparam int AW = 3;
  localparam int NI = 3;
  localparam logic [255:0] P =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef logic [SS-1:0][NB-1:0] st_t;

  typedef struct {
    int  g;
    int  rom;
    int  hold;
    st_t s;
    st_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic          busy      [NI];
  st_t           in_state  [NI];
  st_t           out_state [NI];
  logic [AW-1:0] rc_addr   [NI];
  logic [AW-1:0] round_idx [NI];
  st_t           rom_tbl   [NI][8];

  int checks   = 0;
  int failures = 0;

  function automatic int nr_of(int g);
    return (g == 0) ? 7 : ((g == 1) ? 1 : 2);
  endfunction

  // Controller instances, each paired with a behavioural concrete datapath.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NR = (g == 0) ? 7 : ((g == 1) ? 1 : 2);
    st_t          c_dp_in, c_dp_out, c_s;
    logic [255:0] c_sum;

    concrete_round_ctrl #(
      .N_BITS(NB), .STATE_SIZE(SS), .NUM_ROUNDS(NR), .RC_ADDR_W(AW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_state(in_state[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_state(out_state[g]),
      .dp_in_state(c_dp_in), .dp_out_state(c_dp_out),
      .rc_addr(rc_addr[g]), .busy(busy[g]), .round_idx(round_idx[g])
    );

    // The datapath registers its input state and the element sum every cycle.
    always @(posedge clk) begin
      c_s   <= c_dp_in;
      c_sum <= (256'(c_dp_in[0]) + 256'(c_dp_in[1]) + 256'(c_dp_in[2])) % P;
    end

    // Output is combinational in the round constants addressed by rc_addr.
    always_comb begin
      c_dp_out = '0;
      for (int i = 0; i < SS; i++)
        c_dp_out[i] = NB'((256'(c_s[i]) + 256'(rom_tbl[g][rc_addr[g]][i]) + c_sum) % P);
    end
  end

  function automatic st_t mk(logic [NB-1:0] a, logic [NB-1:0] b, logic [NB-1:0] c);
    st_t r;
    r[0] = a; r[1] = b; r[2] = c;
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_fe();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return NB'(v % P);
  endfunction

  // Reference permutation. Each round adds the round constant and the state
  // sum to every element, all mod p.
  function automatic st_t ref_perm(int g, int nr, st_t s);
    st_t          r;
    logic [255:0] sum;
    r = s;
    for (int rr = 0; rr < nr; rr++) begin
      sum = (256'(r[0]) + 256'(r[1]) + 256'(r[2])) % P;
      for (int i = 0; i < SS; i++)
        r[i] = NB'((256'(r[i]) + 256'(rom_tbl[g][rr][i]) + sum) % P);
    end
    return r;
  endfunction

  // ROM contents: 0 zero, 1 rc(r)=r+1, 2 all ones, 3 random field elements.
  task automatic set_rom(int g, int mode);
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < SS; i++)
        case (mode)
          0:       rom_tbl[g][r][i] = '0;
          1:       rom_tbl[g][r][i] = NB'(r + 1);
          2:       rom_tbl[g][r][i] = NB'(1);
          default: rom_tbl[g][r][i] = rand_fe();
        endcase
  endtask

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_st(string name, st_t act, st_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full permutation. The task checks per-cycle status and exact latency,
  // holds off out_ready for 'hold' cycles while pulsing in_valid, and then
  // returns the captured result.
  task automatic run_perm(int g, st_t s, int hold, output st_t res);
    int n;
    int nr;
    nr = nr_of(g);
    n  = 0;
    while (!in_ready[g] && n < 50) begin
      step();
      n++;
    end
    check($sformatf("in_ready_idle g%0d", g), 256'(in_ready[g]), 256'd1);
    in_state[g] = s;
    in_valid[g] = 1'b1;
    step();
    in_valid[g] = 1'b0;
    in_state[g] = ~s;
    for (int j = 0; j < 2 * nr; j++) begin
      check($sformatf("busy g%0d j%0d", g, j), 256'(busy[g]), 256'd1);
      check($sformatf("rc_addr g%0d j%0d", g, j), 256'(rc_addr[g]), 256'(j / 2));
      check($sformatf("round_idx g%0d j%0d", g, j), 256'(round_idx[g]), 256'(j / 2));
      check($sformatf("early_out_valid g%0d j%0d", g, j), 256'(out_valid[g]), 256'd0);
      check($sformatf("in_ready_busy g%0d j%0d", g, j), 256'(in_ready[g]), 256'd0);
      step();
    end
    check($sformatf("out_valid_latency g%0d", g), 256'(out_valid[g]), 256'd1);
    check($sformatf("busy_done g%0d", g), 256'(busy[g]), 256'd0);
    res = out_state[g];
    out_ready[g] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid[g] = h[0];
      in_state[g] = mk(NB'(h + 100), NB'(h), NB'(h));
      step();
      check($sformatf("hold_out_valid g%0d h%0d", g, h), 256'(out_valid[g]), 256'd1);
      check_st($sformatf("hold_out_state g%0d h%0d", g, h), out_state[g], res);
      check($sformatf("hold_in_ready g%0d h%0d", g, h), 256'(in_ready[g]), 256'd0);
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    step();
    out_ready[g] = 1'b0;
    check($sformatf("in_ready_after_hs g%0d", g), 256'(in_ready[g]), 256'd1);
    check($sformatf("out_valid_after_hs g%0d", g), 256'(out_valid[g]), 256'd0);
    step();
    check($sformatf("no_restart g%0d", g), 256'(busy[g]), 256'd0);
  endtask

  vec_t vecs[6];

  initial begin
    st_t res;
    st_t s;
    st_t e;
    int  seen;
    int  g;

    vecs[0] = '{g: 1, rom: 0, hold: 0, s: mk(1, 2, 3), e: mk(7, 8, 9)};
    vecs[1] = '{g: 1, rom: 0, hold: 0, s: mk(NB'(P - 1), 0, 0),
                e: mk(NB'(P - 2), NB'(P - 1), NB'(P - 1))};
    vecs[2] = '{g: 2, rom: 0, hold: 0, s: mk(1, 2, 3), e: mk(31, 32, 33)};
    vecs[3] = '{g: 0, rom: 2, hold: 5, s: mk(0, 0, 0), e: mk(5461, 5461, 5461)};
    vecs[4] = '{g: 0, rom: 1, hold: 0, s: mk(0, 0, 0), e: mk(7279, 7279, 7279)};
    vecs[5] = '{g: 2, rom: 1, hold: 2, s: mk(1, 2, 3), e: mk(37, 38, 39)};

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_state[i]  = '0;
      set_rom(i, 0);
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_out_valid g%0d", i), 256'(out_valid[i]), 256'd0);
      check($sformatf("rst_busy g%0d", i), 256'(busy[i]), 256'd0);
      check($sformatf("rst_in_ready g%0d", i), 256'(in_ready[i]), 256'd1);
      check($sformatf("rst_rc_addr g%0d", i), 256'(rc_addr[i]), 256'd0);
      check_st($sformatf("rst_out_state g%0d", i), out_state[i], '0);
    end
    rst = 1'b0;
    step();

    // Hand-derived vectors
    for (int v = 0; v < 6; v++) begin
      set_rom(vecs[v].g, vecs[v].rom);
      run_perm(vecs[v].g, vecs[v].s, vecs[v].hold, res);
      check_st($sformatf("vec%0d out_state", v), res, vecs[v].e);
    end

    // Reset during the third CAPTURE cycle of a 7-round permutation
    set_rom(0, 3);
    in_state[0] = mk(1, 2, 3);
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    repeat (5) step();
    check("pre_rst_round_idx", 256'(round_idx[0]), 256'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 256'(out_valid[0]), 256'd0);
    check("mid_rst_busy", 256'(busy[0]), 256'd0);
    check("mid_rst_in_ready", 256'(in_ready[0]), 256'd1);
    check("mid_rst_round_idx", 256'(round_idx[0]), 256'd0);
    check_st("mid_rst_out_state", out_state[0], '0);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid[0] || busy[0]) seen++;
    end
    check("abandoned_no_output", 256'(seen), 256'd0);
    set_rom(1, 0);
    run_perm(1, mk(1, 2, 3), 0, res);
    check_st("post_rst_out_state", res, mk(7, 8, 9));

    // Randomized permutations against the reference model
    for (int k = 0; k < 24; k++) begin
      g = $urandom_range(0, NI - 1);
      set_rom(g, 3);
      s = mk(rand_fe(), rand_fe(), rand_fe());
      e = ref_perm(g, nr_of(g), s);
      run_perm(g, s, $urandom_range(0, 3), res);
      check_st($sformatf("rand%0d g%0d out_state", k, g), res, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
